// File: rtl/keymgr_pkg.sv
// Shared keymgr types and constants: the LFSR permutation table type, its default
// value and the inverse-table FSM state encoding.
package keymgr_pkg;

  localparam int unsigned LfsrWidth = 64;
  localparam int unsigned LfsrIdxW  = 6;

  // Entry i names the raw LFSR bit that lands on permuted bit i.
  typedef logic [LfsrWidth-1:0][LfsrIdxW-1:0] lfsr_perm_t;

  typedef enum logic [1:0] {
    StInit,
    StActive,
    StError
  } lfsr_unperm_state_e;

  // Affine map with an odd multiplier, which is always a bijection modulo 2^LfsrIdxW.
  function automatic lfsr_perm_t gen_default_perm();
    lfsr_perm_t p;
    for (int unsigned i = 0; i < LfsrWidth; i++) begin
      p[i] = LfsrIdxW'((37 * i + 11) % LfsrWidth);
    end
    return p;
  endfunction

  localparam lfsr_perm_t RndCnstLfsrPermDefault = gen_default_perm();

endpackage

// File: rtl/keymgr_lfsr_inv_table.sv
// Serially builds the inverse of a forward permutation table, one entry per cycle, and
// flags a duplicate entry (non-bijective constant) as a sticky error.
module keymgr_lfsr_inv_table
  import keymgr_pkg::*;
#(
  parameter lfsr_perm_t Perm = RndCnstLfsrPermDefault
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               reinit_i,
  output logic [LfsrWidth-1:0][LfsrIdxW-1:0] inv_o,
  output logic                               done_o,
  output logic                               err_o
);

  localparam logic [LfsrIdxW:0] LastIdx = (LfsrIdxW + 1)'(LfsrWidth - 1);

  lfsr_unperm_state_e                 state_q;
  logic [LfsrIdxW:0]                  idx_q;
  logic [LfsrWidth-1:0]               seen_q;
  logic [LfsrWidth-1:0][LfsrIdxW-1:0] inv_q;
  logic                               done_q;
  logic                               err_q;
  logic [LfsrIdxW-1:0]                p;

  assign p = Perm[idx_q[LfsrIdxW-1:0]];

  // 64 distinct 6-bit targets cover every slot, so no closing scan of seen_q is needed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      idx_q   <= '0;
      seen_q  <= '0;
      inv_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (reinit_i) begin
      state_q <= StInit;
      idx_q   <= '0;
      seen_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (seen_q[p]) begin
            state_q <= StError;
            err_q   <= 1'b1;
          end else begin
            inv_q[p]  <= idx_q[LfsrIdxW-1:0];
            seen_q[p] <= 1'b1;
            idx_q     <= idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              state_q <= StActive;
              done_q  <= 1'b1;
            end
          end
        end
        StActive, StError: ;
        default: begin
          state_q <= StError;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign inv_o  = inv_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: rtl/keymgr_lfsr_unperm.sv
// Recovers the raw LFSR word from its permuted form through a one-deep registered
// valid/ready stage, once the inverse permutation table has been built.
module keymgr_lfsr_unperm
  import keymgr_pkg::*;
#(
  parameter lfsr_perm_t RndCnstLfsrPerm = RndCnstLfsrPermDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reinit_i,
  input  logic                 data_valid_i,
  input  logic [LfsrWidth-1:0] data_i,
  output logic                 data_ready_o,
  output logic                 data_valid_o,
  output logic [LfsrWidth-1:0] data_o,
  input  logic                 data_ready_i,
  output logic                 init_done_o,
  output logic                 perm_err_o
);

  logic [LfsrWidth-1:0][LfsrIdxW-1:0] inv;
  logic                               tbl_done;
  logic                               tbl_err;

  keymgr_lfsr_inv_table #(
    .Perm (RndCnstLfsrPerm)
  ) u_inv_table (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .reinit_i (reinit_i),
    .inv_o    (inv),
    .done_o   (tbl_done),
    .err_o    (tbl_err)
  );

  logic                 init_done_q;
  logic                 perm_err_q;
  logic                 valid_q, valid_d;
  logic [LfsrWidth-1:0] data_q, data_d;
  logic [LfsrWidth-1:0] unperm;
  logic                 accept;

  always_comb begin
    unperm = '0;
    for (int unsigned j = 0; j < LfsrWidth; j++) begin
      unperm[j] = data_i[inv[j]];
    end
  end

  // reinit_i blocks acceptance so a word presented alongside it is never captured.
  assign data_ready_o = init_done_q & ~reinit_i & (~valid_q | data_ready_i);
  assign accept       = data_valid_i & data_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (reinit_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = unperm;
    end else if (valid_q && data_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_done_q <= 1'b0;
      perm_err_q  <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      init_done_q <= ~reinit_i & tbl_done;
      perm_err_q  <= ~reinit_i & tbl_err;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign data_valid_o = valid_q;
  assign data_o       = data_q;
  assign init_done_o  = init_done_q;
  assign perm_err_o   = perm_err_q;

endmodule

// File: tb/tb_keymgr_lfsr_unperm.sv
// Directed bench: identity, reversal, default and duplicate-entry permutations, each on its
// own instance sharing one clock and reset.
module tb_keymgr_lfsr_unperm;
  import keymgr_pkg::*;

  localparam int NInst = 4;  // 0 identity, 1 reversal, 2 default, 3 duplicate

  logic        clk;
  logic        rst_n;
  logic        reinit    [NInst];
  logic        dvalid    [NInst];
  logic        dready_in [NInst];
  logic        ready_o   [NInst];
  logic        valid_o   [NInst];
  logic        init_done [NInst];
  logic        perm_err  [NInst];
  logic [63:0] din       [NInst];
  logic [63:0] data_o    [NInst];

  int n_vec;
  int n_err;
  int done_cyc [NInst];
  int err_cyc  [NInst];
  bit rdy_seen3;

  function automatic lfsr_perm_t tb_perm(input int k);
    lfsr_perm_t p;
    for (int i = 0; i < 64; i++) begin
      case (k)
        1:       p[i] = 6'(63 - i);
        2:       p[i] = RndCnstLfsrPermDefault[i];
        default: p[i] = 6'(i);
      endcase
    end
    if (k == 3) begin
      p[3] = 6'd5;
      p[5] = 6'd3;
      p[9] = 6'd3;
    end
    return p;
  endfunction

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    keymgr_lfsr_unperm #(
      .RndCnstLfsrPerm (tb_perm(g))
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .reinit_i     (reinit[g]),
      .data_valid_i (dvalid[g]),
      .data_i       (din[g]),
      .data_ready_o (ready_o[g]),
      .data_valid_o (valid_o[g]),
      .data_o       (data_o[g]),
      .data_ready_i (dready_in[g]),
      .init_done_o  (init_done[g]),
      .perm_err_o   (perm_err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Producer side: perm[i] = raw[P[i]] with the default constant.
  function automatic logic [63:0] fwd(input logic [63:0] raw);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[i] = raw[RndCnstLfsrPermDefault[i]];
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Call just after the edge that starts initialisation; cycle c is the c-th edge after it.
  task automatic wait_init(input int limit);
    for (int k = 0; k < NInst; k++) begin
      done_cyc[k] = -1;
      err_cyc[k]  = -1;
    end
    rdy_seen3 = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NInst; k++) begin
        if (done_cyc[k] < 0 && init_done[k]) done_cyc[k] = c;
        if (err_cyc[k] < 0 && perm_err[k]) err_cyc[k] = c;
      end
      if (ready_o[3] || valid_o[3]) rdy_seen3 = 1'b1;
    end
  endtask

  task automatic apply_vec(input int k, input logic [63:0] d, input logic [63:0] e);
    @(negedge clk);
    din[k]       = d;
    dvalid[k]    = 1'b1;
    dready_in[k] = 1'b1;
    #1;
    check($sformatf("vec%0d_ready", k), 64'(ready_o[k]), 64'd1);
    @(posedge clk);
    #1;
    dvalid[k] = 1'b0;
    check($sformatf("vec%0d_valid", k), 64'(valid_o[k]), 64'd1);
    check($sformatf("vec%0d_data", k), data_o[k], e);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_drained", k), 64'(valid_o[k]), 64'd0);
  endtask

  typedef struct {
    int          inst;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin : main
    logic [63:0] q[$];
    logic [63:0] cur_raw, held, expv, raw_a, raw_b;
    bit          stalled, acc_in;
    int          sent, got;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int k = 0; k < NInst; k++) begin
      reinit[k]    = 1'b0;
      dvalid[k]    = 1'b0;
      dready_in[k] = 1'b1;
      din[k]       = '0;
    end

    raw_a = 64'h0123_4567_89AB_CDEF;
    raw_b = 64'hA5A5_0000_FFFF_1234;
    vecs.push_back('{0, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567});
    vecs.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{1, 64'h1, 64'h8000_0000_0000_0000});
    vecs.push_back('{1, 64'hF, 64'hF000_0000_0000_0000});
    vecs.push_back('{1, 64'h8000_0000_0000_0000, 64'h1});
    vecs.push_back('{1, 64'h0123_4567_89AB_CDEF, 64'hF7B3_D591_E6A2_C480});
    vecs.push_back('{2, fwd(raw_a), raw_a});
    vecs.push_back('{2, fwd(raw_b), raw_b});

    // Reset state
    #7;
    for (int k = 0; k < NInst; k++) begin
      check($sformatf("rst%0d_ready", k), 64'(ready_o[k]), 64'd0);
      check($sformatf("rst%0d_valid", k), 64'(valid_o[k]), 64'd0);
      check($sformatf("rst%0d_done", k), 64'(init_done[k]), 64'd0);
      check($sformatf("rst%0d_err", k), 64'(perm_err[k]), 64'd0);
      check($sformatf("rst%0d_data", k), data_o[k], 64'd0);
    end

    // Initialisation latency and duplicate detection
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(70);
    for (int k = 0; k < 3; k++) check($sformatf("init%0d_latency", k), 64'(done_cyc[k]), 64'd65);
    check("dup_err_cycle", 64'(err_cyc[3]), 64'd11);
    check("dup_no_done", 64'(done_cyc[3]), 64'(-1));
    check("dup_no_ready", 64'(rdy_seen3), 64'd0);
    check("ident_no_err", 64'(err_cyc[0]), 64'(-1));

    foreach (vecs[i]) apply_vec(vecs[i].inst, vecs[i].din, vecs[i].exp);

    // Default constant streamed with random backpressure
    sent    = 0;
    got     = 0;
    stalled = 1'b0;
    acc_in  = 1'b0;
    cur_raw = '0;
    held    = '0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", 64'(valid_o[2]), 64'd1);
        check("stall_data", data_o[2], held);
      end
      if (acc_in) dvalid[2] = 1'b0;
      if (!dvalid[2] && sent < 1000) begin
        cur_raw   = {$urandom, $urandom};
        din[2]    = fwd(cur_raw);
        dvalid[2] = 1'b1;
      end
      dready_in[2] = 1'($urandom_range(0, 1));
      #1;
      acc_in = dvalid[2] && ready_o[2];
      if (valid_o[2] && dready_in[2]) begin
        if (q.size() == 0) begin
          check("stream_extra_word", 64'(valid_o[2]), 64'd0);
        end else begin
          expv = q.pop_front();
          check("stream_data", data_o[2], expv);
          got++;
        end
      end
      stalled = valid_o[2] && !dready_in[2];
      held    = data_o[2];
      if (acc_in) begin
        q.push_back(cur_raw);
        sent++;
      end
    end
    dvalid[2]    = 1'b0;
    dready_in[2] = 1'b1;
    check("stream_count", 64'(got), 64'd1000);
    check("stream_leftover", 64'(q.size()), 64'd0);

    // reinit clears the sticky error, which returns at the same offset
    @(negedge clk);
    reinit[3] = 1'b1;
    @(posedge clk);
    #1;
    reinit[3] = 1'b0;
    check("reinit_err_clear", 64'(perm_err[3]), 64'd0);
    wait_init(20);
    check("reinit_err_cycle", 64'(err_cyc[3]), 64'd11);
    check("reinit_dup_no_ready", 64'(rdy_seen3), 64'd0);

    // reinit while a word is stalled at the output
    @(negedge clk);
    din[0]       = 64'hCAFE_F00D_1234_5678;
    dvalid[0]    = 1'b1;
    dready_in[0] = 1'b0;
    @(posedge clk);
    #1;
    dvalid[0] = 1'b0;
    check("stall0_valid", 64'(valid_o[0]), 64'd1);
    @(negedge clk);
    check("stall0_held", data_o[0], 64'hCAFE_F00D_1234_5678);
    reinit[0] = 1'b1;
    dvalid[0] = 1'b1;
    din[0]    = 64'h1111_2222_3333_4444;
    #1;
    check("reinit_blocks_ready", 64'(ready_o[0]), 64'd0);
    @(posedge clk);
    #1;
    reinit[0]    = 1'b0;
    dvalid[0]    = 1'b0;
    dready_in[0] = 1'b1;
    check("reinit_valid_drop", 64'(valid_o[0]), 64'd0);
    check("reinit_done_drop", 64'(init_done[0]), 64'd0);
    wait_init(70);
    check("reinit_latency", 64'(done_cyc[0]), 64'd65);
    check("reinit_no_word", 64'(valid_o[0]), 64'd0);

    // Asynchronous reset mid-transfer, then again mid-initialisation
    @(negedge clk);
    din[0]       = 64'h5555_AAAA_5555_AAAA;
    dvalid[0]    = 1'b1;
    dready_in[0] = 1'b0;
    @(posedge clk);
    #1;
    dvalid[0] = 1'b0;
    check("pre_rst_valid", 64'(valid_o[0]), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(valid_o[0]), 64'd0);
    check("arst_data", data_o[0], 64'd0);
    check("arst_done", 64'(init_done[0]), 64'd0);
    check("arst_err", 64'(perm_err[3]), 64'd0);
    dready_in[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(30);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_init_done", 64'(init_done[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(70);
    for (int k = 0; k < 3; k++) check($sformatf("rinit%0d_latency", k), 64'(done_cyc[k]), 64'd65);
    check("rinit_err_cycle", 64'(err_cyc[3]), 64'd11);
    apply_vec(0, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
